// File: rtl/sc_core_oz_lsu.sv
// RV32I load/store unit: ALU result as effective address, req/gnt/rvalid data port, core stall, load extension.
// Optional bus-timeout abort is enabled by defining SC_CORE_OZ_LSU_TIMEOUT_EN.
module sc_core_oz_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        access_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sc_core_oz_lsu: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic        we_reg;
  logic [2:0]  f3_reg;
  logic [4:0]  rd_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] wb_data_reg;
  logic [4:0]  wb_rd_reg;

  logic        illegal, unaligned, launch, capture, timeout;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, byte_sh, half_sh, load_ext;

  // Stores only support B/H/W; loads add the unsigned BU/HU forms.
  always_comb begin
    if (lsu_we) illegal = (funct3 > 3'b010);
    else        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    unaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << addr[1:0];
        wdata_in = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_in    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{st_data[15:0]}};
      end
      default: begin
        be_in    = 4'hF;
        wdata_in = st_data;
      end
    endcase
  end

  always_comb begin
    byte_sh = mem_rdata >> {addr_reg[1:0], 3'b000};
    half_sh = mem_rdata >> {addr_reg[1], 4'b0000};
    case (f3_reg)
      3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_ext = {24'd0, byte_sh[7:0]};
      3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_ext = {16'd0, half_sh[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

`ifdef SC_CORE_OZ_LSU_TIMEOUT_EN
  logic [15:0] cnt_reg;
  assign timeout = ((state_reg == REQ) || (state_reg == WAIT)) && (cnt_reg == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        cnt_reg <= 16'd0;
    else if (launch)                                 cnt_reg <= 16'd0;
    else if ((state_reg == REQ) || (state_reg == WAIT)) cnt_reg <= cnt_reg + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    mem_req    = 1'b0;
    misalign   = 1'b0;
    access_err = 1'b0;
    wb_valid   = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lsu_valid) begin
          if (illegal)        access_err = 1'b1;
          else if (unaligned) misalign   = 1'b1;
          else begin
            stall      = 1'b1;
            launch     = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          access_err = 1'b1;
          state_next = IDLE;
        end else begin
          mem_req = 1'b1;
          stall   = 1'b1;
          if (mem_gnt) state_next = we_reg ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (timeout) begin
          access_err = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
          if (mem_rvalid) begin
            capture    = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: begin
        wb_valid   = !we_reg && (rd_reg != 5'd0);
        state_next = IDLE;
      end
    endcase
    // IDLE decode is combinational on lsu_valid, so mask it while reset is held.
    if (!rst) begin
      stall      = 1'b0;
      misalign   = 1'b0;
      access_err = 1'b0;
      launch     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      addr_reg    <= 32'd0;
      we_reg      <= 1'b0;
      f3_reg      <= 3'd0;
      rd_reg      <= 5'd0;
      be_reg      <= 4'd0;
      wdata_reg   <= 32'd0;
      wb_data_reg <= 32'd0;
      wb_rd_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        addr_reg  <= addr;
        we_reg    <= lsu_we;
        f3_reg    <= funct3;
        rd_reg    <= rd;
        be_reg    <= be_in;
        wdata_reg <= wdata_in;
      end
      if (capture) begin
        wb_data_reg <= load_ext;
        wb_rd_reg   <= rd_reg;
      end
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = {addr_reg[31:2], 2'b00};
  assign mem_be    = be_reg;
  assign mem_wdata = wdata_reg;
  assign wb_data   = wb_data_reg;
  assign wb_rd     = wb_rd_reg;

endmodule

// File: tb/tb_sc_core_oz_lsu.sv
// Directed bench for sc_core_oz_lsu: vector table with a simple memory responder plus reset/ordering sequences.
module tb_sc_core_oz_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic [4:0]  rd;
  logic        stall, wb_valid, misalign, access_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_wb = 32'd0;
  logic [4:0]  last_rd = 5'd0;

  always #5 clk = ~clk;

  sc_core_oz_lsu #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_we(lsu_we), .funct3(funct3),
    .addr(addr), .st_data(st_data), .rd(rd), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .access_err(access_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gc;      // grant on this REQ cycle (1 = immediate)
    int          rc;      // rvalid on this WAIT cycle (1 = earliest)
    logic        e_err;
    logic        e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, w, stalls;
    logic granted, done;
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = v.we; funct3 = v.f3; addr = v.addr; st_data = v.st; rd = v.rd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d access_err", idx), 32'(access_err), 32'(v.e_err));
    chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'(v.e_mis));
    chk($sformatf("v%0d idle_mem_req", idx), 32'(mem_req), 32'd0);
    if (v.e_err || v.e_mis) begin
      chk($sformatf("v%0d err_stall", idx), 32'(stall), 32'd0);
      chk($sformatf("v%0d err_wb_hold", idx), wb_data, last_wb);
      @(posedge clk); #1;
      lsu_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d err_no_req", idx), 32'(mem_req), 32'd0);
    end else begin
      stalls = stall ? 1 : 0;
      k = 0; w = 0; granted = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        if (mem_req) begin
          k++;
          if (k == v.gc) mem_gnt = 1'b1;
        end else if (stall && granted) begin
          w++;
          if (w == v.rc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
          end
        end
        @(negedge clk);
        if (mem_req && k == 1) begin
          chk($sformatf("v%0d mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we));
          if (v.we) begin
            chk($sformatf("v%0d mem_be", idx), 32'(mem_be), 32'(v.e_be));
            chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
          end
        end
        if (mem_gnt) granted = 1'b1;
        if (stall) stalls++;
        else done = 1'b1;
      end
      if (!done) begin
        fails++; tests++;
        $display("FAIL v%0d completion: no DONE within 60 cycles", idx);
      end else begin
        chk($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(1 + v.gc + (v.we ? 0 : v.rc)));
        chk($sformatf("v%0d wb_valid", idx), 32'(wb_valid), 32'(!v.we && v.rd != 5'd0));
        if (!v.we) begin
          last_wb = v.e_wb;
          last_rd = v.rd;
        end
        if (!v.we && v.rd != 5'd0) chk($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(v.rd));
        chk($sformatf("v%0d wb_data", idx), wb_data, last_wb);
      end
      @(posedge clk); #1;
      lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d post_wb_valid", idx), 32'(wb_valid), 32'd0);
    end
  endtask

  initial begin
    //        we   f3    addr          st            rd  rdata         gc rc err  mis  be       wdata         wb
    vt[0]  = '{1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  32'd0,        1, 0, 1'b0, 1'b0, 4'hF,    32'hDEAD_BEEF, 32'd0};
    vt[1]  = '{1'b0, 3'd0, 32'h0000_0203, 32'd0,         5'd5,  32'h80FF_1234, 1, 1, 1'b0, 1'b0, 4'h0,    32'd0,         32'hFFFF_FF80};
    vt[2]  = '{1'b0, 3'd4, 32'h0000_0203, 32'd0,         5'd6,  32'h80FF_1234, 1, 1, 1'b0, 1'b0, 4'h0,    32'd0,         32'h0000_0080};
    vt[3]  = '{1'b1, 3'd1, 32'h0000_0302, 32'h0000_ABCD, 5'd0,  32'd0,        1, 0, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'd0};
    vt[4]  = '{1'b0, 3'd2, 32'h0000_0101, 32'd0,         5'd1,  32'd0,        1, 1, 1'b0, 1'b1, 4'h0,    32'd0,         32'd0};
    vt[5]  = '{1'b0, 3'd3, 32'h0000_0000, 32'd0,         5'd1,  32'd0,        1, 1, 1'b1, 1'b0, 4'h0,    32'd0,         32'd0};
    vt[6]  = '{1'b0, 3'd1, 32'h0000_0102, 32'd0,         5'd0,  32'h8001_7FFF, 5, 2, 1'b0, 1'b0, 4'h0,    32'd0,         32'hFFFF_8001};
    vt[7]  = '{1'b0, 3'd5, 32'h0000_0000, 32'd0,         5'd7,  32'h1234_F00D, 1, 1, 1'b0, 1'b0, 4'h0,    32'd0,         32'h0000_F00D};
    vt[8]  = '{1'b0, 3'd2, 32'h0000_0004, 32'd0,         5'd31, 32'hCAFE_F00D, 2, 3, 1'b0, 1'b0, 4'h0,    32'd0,         32'hCAFE_F00D};
    vt[9]  = '{1'b1, 3'd0, 32'h0000_0006, 32'h1234_56A5, 5'd0,  32'd0,        3, 0, 1'b0, 1'b0, 4'b0100, 32'hA5A5_A5A5, 32'd0};
    vt[10] = '{1'b1, 3'd3, 32'h0000_0000, 32'h1111_1111, 5'd0,  32'd0,        1, 0, 1'b1, 1'b0, 4'h0,    32'd0,         32'd0};
    vt[11] = '{1'b1, 3'd4, 32'h0000_0000, 32'h1111_1111, 5'd0,  32'd0,        1, 0, 1'b1, 1'b0, 4'h0,    32'd0,         32'd0};
    vt[12] = '{1'b1, 3'd1, 32'h0000_0301, 32'h1111_1111, 5'd0,  32'd0,        1, 0, 1'b0, 1'b1, 4'h0,    32'd0,         32'd0};
    vt[13] = '{1'b0, 3'd7, 32'h0000_0003, 32'd0,         5'd2,  32'd0,        1, 1, 1'b1, 1'b0, 4'h0,    32'd0,         32'd0};
    vt[14] = '{1'b0, 3'd0, 32'h0000_0201, 32'd0,         5'd9,  32'h0000_7F00, 1, 1, 1'b0, 1'b0, 4'h0,    32'd0,         32'h0000_007F};
    vt[15] = '{1'b0, 3'd6, 32'h0000_0000, 32'd0,         5'd2,  32'd0,        1, 1, 1'b1, 1'b0, 4'h0,    32'd0,         32'd0};
    vt[16] = '{1'b1, 3'd2, 32'h0000_0002, 32'h2222_2222, 5'd0,  32'd0,        1, 0, 1'b0, 1'b1, 4'h0,    32'd0,         32'd0};

    rst = 1'b0; lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'd2; addr = 32'd0; st_data = 32'd0; rd = 5'd1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    lsu_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_vec(i, vt[i]);
      $display("[TB] vector %0d done (we=%0b f3=%0d addr=0x%08h)", i, vt[i].we, vt[i].f3, vt[i].addr);
    end

    // Reset while a load waits for rvalid.
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'd2; addr = 32'h40; rd = 5'd3;
    @(posedge clk); #1 mem_gnt = 1'b1;
    chk("rstwait req", 32'(mem_req), 32'd1);
    @(posedge clk); #1 mem_gnt = 1'b0;
    chk("rstwait stall_before", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstwait stall_async", 32'(stall), 32'd0);
    chk("rstwait mem_req", 32'(mem_req), 32'd0);
    chk("rstwait wb_data", wb_data, 32'd0);
    lsu_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    $display("[TB] reset-in-WAIT sequence done");

    // Reset while a store is requesting.
    lsu_valid = 1'b1; lsu_we = 1'b1; funct3 = 3'd2; addr = 32'h80; st_data = 32'h1122_3344;
    @(negedge clk);
    chk("rstreq idle_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("rstreq mem_req", 32'(mem_req), 32'd1);
    chk("rstreq mem_addr", mem_addr, 32'h80);
    #2 rst = 1'b0;
    #1;
    chk("rstreq mem_req_async", 32'(mem_req), 32'd0);
    chk("rstreq stall_async", 32'(stall), 32'd0);
    lsu_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    $display("[TB] reset-in-REQ sequence done");

    // Early rvalid during REQ must be ignored; only the WAIT response is captured.
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'd4; addr = 32'h21; rd = 5'd4;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'h0000_AA00;
    @(negedge clk);
    chk("early_rv req", 32'(mem_req), 32'd1);
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    chk("early_rv still_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1100;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    chk("early_rv wb_valid", 32'(wb_valid), 32'd1);
    chk("early_rv wb_data", wb_data, 32'h0000_0011);
    chk("early_rv wb_rd", 32'(wb_rd), 32'd4);
    chk("early_rv done_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 lsu_valid = 1'b0;
    @(negedge clk);
    chk("early_rv no_relaunch", 32'(mem_req), 32'd0);
    chk("early_rv wb_pulse", 32'(wb_valid), 32'd0);
    $display("[TB] early-rvalid sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
